// File: rtl/rv32i_decode_pkg.sv
// Shared decode definitions for the RV32I ID stage: opcodes, class codes and the decode bundle.
// The muldiv bundle field exists only when RV32M_DECODE_EN is defined.
package rv32i_decode_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   typedef enum logic [3:0] {
      CLS_LUI     = 4'd0,
      CLS_AUIPC   = 4'd1,
      CLS_JAL     = 4'd2,
      CLS_JALR    = 4'd3,
      CLS_BRANCH  = 4'd4,
      CLS_LOAD    = 4'd5,
      CLS_STORE   = 4'd6,
      CLS_OP_IMM  = 4'd7,
      CLS_OP      = 4'd8,
      CLS_FENCE   = 4'd9,
      CLS_SYSTEM  = 4'd10,
      CLS_ILLEGAL = 4'd15
   } iclass_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
      iclass_e     cls;
      logic        illegal;
`ifdef RV32M_DECODE_EN
      logic        muldiv;
`endif
   } decode_t;

endpackage

// File: rtl/rv32i_decode_comb.sv
// Purely combinational RV32I decoder: instruction word -> register fields, immediate, class, legality.
// With RV32M_DECODE_EN defined, OP with funct7=0000001 is legal and flagged as muldiv.
module rv32i_decode_comb
   import rv32i_decode_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] ir,
   output decode_t     bundle
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        legal;
   logic [31:0] imm;
   iclass_e     cls;
`ifdef RV32M_DECODE_EN
   logic        muldiv;
`endif

   assign opcode = ir[6:0];
   assign funct3 = ir[14:12];
   assign funct7 = ir[31:25];

   assign imm_i = {{20{ir[31]}}, ir[31:20]};
   assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   assign imm_u = {ir[31:12], 12'b0};
   assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can leave it unassigned and infer a latch.
      legal = 1'b0;
      imm   = '0;
      cls   = CLS_ILLEGAL;
`ifdef RV32M_DECODE_EN
      muldiv = 1'b0;
`endif
      // ir[1:0] is part of the opcode, so a non-11 low pair falls into default.
      case (opcode)
         OPC_LUI:    begin cls = CLS_LUI;    imm = imm_u; legal = 1'b1; end
         OPC_AUIPC:  begin cls = CLS_AUIPC;  imm = imm_u; legal = 1'b1; end
         OPC_JAL:    begin cls = CLS_JAL;    imm = imm_j; legal = 1'b1; end
         OPC_JALR:   begin cls = CLS_JALR;   imm = imm_i; legal = (funct3 == 3'b000); end
         OPC_BRANCH: begin cls = CLS_BRANCH; imm = imm_b; legal = (funct3 != 3'b010) && (funct3 != 3'b011); end
         OPC_LOAD:   begin cls = CLS_LOAD;   imm = imm_i; legal = (funct3 != 3'b011) && (funct3 < 3'b110); end
         OPC_STORE:  begin cls = CLS_STORE;  imm = imm_s; legal = (funct3 <= 3'b010); end
         OPC_OP_IMM: begin
            cls = CLS_OP_IMM;
            imm = imm_i;
            if (funct3 == 3'b001)
               legal = (funct7 == F7_BASE);
            else if (funct3 == 3'b101)
               legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            else
               legal = 1'b1;
         end
         OPC_OP: begin
            cls   = CLS_OP;
            legal = (funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
`ifdef RV32M_DECODE_EN
            if (funct7 == F7_MUL) begin
               legal  = 1'b1;
               muldiv = 1'b1;
            end
`endif
         end
         OPC_FENCE:  begin cls = CLS_FENCE;  imm = imm_i; legal = 1'b1; end
         OPC_SYSTEM: begin cls = CLS_SYSTEM; imm = imm_i; legal = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      bundle.pc      = pc;
      bundle.rd      = ir[11:7];
      bundle.rs1     = ir[19:15];
      bundle.rs2     = ir[24:20];
      bundle.funct3  = funct3;
      bundle.funct7  = funct7;
      bundle.imm     = legal ? imm : '0;
      bundle.cls     = legal ? cls : CLS_ILLEGAL;
      bundle.illegal = !legal;
`ifdef RV32M_DECODE_EN
      bundle.muldiv  = legal && muldiv;
`endif
   end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I ID stage: decodes fetched {pc, ir} and presents it to EXE through a 2-entry skid buffer with flush.
// Optional RV32M_DECODE_EN adds M-extension legality and the id_muldiv output.
module rv32i_decode_stage
   import rv32i_decode_pkg::*;
#(
   parameter int                XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = '0
) (
   input  logic            clock_1hz,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [XLEN-1:0] if_pc,
   input  logic [31:0]     if_ir,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [4:0]      id_rd,
   output logic [4:0]      id_rs1,
   output logic [4:0]      id_rs2,
   output logic [2:0]      id_funct3,
   output logic [6:0]      id_funct7,
   output logic [31:0]     id_imm,
   output logic [3:0]      id_class,
   output logic            id_illegal
`ifdef RV32M_DECODE_EN
   ,
   output logic            id_muldiv
`endif
);

   decode_t decoded;
   decode_t main_q, skid_q;
   logic    main_valid, skid_valid;
   logic    accept;

   rv32i_decode_comb u_decode (
      .pc     (if_pc),
      .ir     (if_ir),
      .bundle (decoded)
   );

   // Ready comes from registered state only, keeping id_ready off the fetch timing path.
   assign if_ready = !skid_valid;
   assign accept   = if_valid && if_ready;

   always_ff @(posedge clock_1hz or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the payload registers are reset too, because main_q drives the id_* outputs directly.
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         main_q.pc  <= RESET_PC;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_valid && !id_ready) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         if (accept) begin
            skid_q     <= decoded;
            skid_valid <= 1'b1;
         end
      end else if (skid_valid) begin
         // Main retires with skid occupied; no accept is possible since if_ready is low.
         main_q     <= skid_q;
         main_valid <= 1'b1;
         skid_valid <= 1'b0;
      end else if (accept) begin
         main_q     <= decoded;
         main_valid <= 1'b1;
      end else begin
         main_valid <= 1'b0;
      end
   end

   assign id_valid   = main_valid;
   assign id_pc      = main_q.pc;
   assign id_rd      = main_q.rd;
   assign id_rs1     = main_q.rs1;
   assign id_rs2     = main_q.rs2;
   assign id_funct3  = main_q.funct3;
   assign id_funct7  = main_q.funct7;
   assign id_imm     = main_q.imm;
   assign id_class   = main_q.cls;
   assign id_illegal = main_q.illegal;
`ifdef RV32M_DECODE_EN
   assign id_muldiv  = main_q.muldiv;
`endif

endmodule

// File: doc/rv32i_decode_stage.md
Name: rv32i_decode_stage

Overview:
- ID stage of the on-board RV32I core. It sits between instruction fetch (BRAM read, byte-addressed PC) and the execute stage.
- Accepts fetched {pc, ir} over a valid/ready handshake and decodes the register fields, immediate, instruction class and legality.
- Presents a registered decode bundle to EXE through a 2-entry skid buffer, so EXE back-pressure never drops or duplicates an instruction.
- Flush input discards in-flight instructions on redirect.

Parameters:
- XLEN, 32, datapath and PC width. Only 32 is supported.
- RESET_PC, 32'h0, value driven on id_pc while id_valid=0 after reset.

Ports:
- clock_1hz  in  1  stage clock (slow board clock)
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  discard all buffered and incoming instructions this cycle
- if_valid  in  1  fetch offers an instruction
- if_ready  out  1  stage can accept this cycle
- if_pc  in  32  byte address of if_ir
- if_ir  in  32  raw instruction word
- id_valid  out  1  decode bundle valid
- id_ready  in  1  EXE accepts the bundle
- id_pc  out  32  PC of the decoded instruction
- id_rd, id_rs1, id_rs2  out  5 each  register indices (ir[11:7], ir[19:15], ir[24:20])
- id_funct3  out  3  ir[14:12]
- id_funct7  out  7  ir[31:25]
- id_imm  out  32  sign-extended immediate
- id_class  out  4  instruction class code (see package)
- id_illegal  out  1  instruction is illegal

Behaviour:
- Clock and reset: reset rst_n, asynchronous, active-low; clock clock_1hz.
- Reset values:
  - id_valid=0, id_pc=RESET_PC.
  - All other id_* outputs = 0.
  - Both skid entries are invalid.
  - if_ready=1 in the first cycle after reset release.
- Decoding is combinational on if_ir and captured at the accept edge.
  - Latency is 1 cycle: an accept at edge N makes id_valid=1 after edge N.
- Handshakes:
  - Accept when if_valid && if_ready.
  - Retire when id_valid && id_ready.
  - if_ready = !skid_valid. It depends on state only and never combinationally on id_ready.
- Skid buffer:
  - Entries: main (drives id_*) and skid.
  - Accept while main is empty, or main retires the same cycle: the new entry goes to main.
  - Accept while main is held (id_ready=0): the new entry goes to skid.
  - Main retires while skid is valid: skid moves to main.
  - Order is always preserved. Outputs are stable while id_valid && !id_ready.
- Flush:
  - Has priority over everything else.
  - On the next edge both entries become invalid and the same-cycle input is dropped, even if if_valid && if_ready.
  - id_valid=0 on the next cycle.
- Immediates (all sign-extended from ir[31]):
  - I-type: ir[31:20].
  - S-type: {ir[31:25], ir[11:7]}.
  - B-type: {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
  - U-type: {ir[31:12], 12'b0}.
  - J-type: {ir[31], ir[19:12], ir[20], ir[30:21], 0}.
  - R-type and illegal instructions: 0.
- Class codes: LUI=0, AUIPC=1, JAL=2, JALR=3, BRANCH=4, LOAD=5, STORE=6, OP_IMM=7, OP=8, FENCE=9, SYSTEM=10, ILLEGAL=15.
- Illegal conditions (any one sets id_illegal=1, id_class=15, id_imm=0; the bundle still flows downstream):
  - ir[1:0] != 2'b11, or the opcode is unknown.
  - JALR with funct3 != 0.
  - BRANCH with funct3 of 010 or 011.
  - LOAD with funct3 of 011, 110 or 111.
  - STORE with funct3 > 010.
  - OP with funct7 not 0000000 / 0100000, or funct7=0100000 with funct3 not 000 / 101.
  - OP_IMM shift with an invalid funct7: SLLI needs 0000000; SRLI/SRAI need 0000000 / 0100000.

Optional Feature:
- Macro: RV32M_DECODE_EN.
- Defined:
  - OP with funct7=0000001 is legal, id_class=OP (8).
  - Adds output id_muldiv (1 bit). It is set for these instructions and 0 on reset.
- Undefined:
  - funct7=0000001 is illegal.
  - No id_muldiv port exists.

Decomposition:
- Package rv32i_decode_pkg holds:
  - the opcode localparams (7 bits each);
  - the class codes (4 bits);
  - the decode bundle struct {pc, rd, rs1, rs2, funct3, funct7, imm, class, illegal [, muldiv]}.
- Sub-module rv32i_decode_comb is purely combinational: ir -> bundle fields, immediate and legality.
- The top module holds only the skid buffer and flush control.

Test Plan:
- LUI 0x123450B7 at pc 0x10, id_ready=1 -> next cycle id_valid=1, class 0, rd 1, imm 0x12345000, id_pc 0x10.
- ADDI 0xFFF00093, then BEQ 0xFE000EE3 back-to-back -> imm 0xFFFFFFFF (class 7), then imm 0xFFFFFFFC (class 4, rs1=rs2=0); one per cycle.
- Three consecutive valid inputs with id_ready=0 -> first two accepted, if_ready=0 on the third. Raise id_ready -> all three emerge in order with no duplicates.
- 0x00000000 and 0x02208033 (MUL) -> both illegal (class 15, imm 0) without RV32M_DECODE_EN. With the macro, MUL is legal, class 8, id_muldiv=1.
- Fill both entries, then pulse flush together with a new if_valid -> id_valid=0 next cycle, the flushed word never appears, if_ready returns to 1.
- Assert rst_n=0 mid-stream asynchronously -> id_valid=0 immediately; after release if_ready=1 and id_pc=RESET_PC.
